pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer for the OTTER core.
- Holds PC and drives it to the +4 adder and instruction memory.
- Selects the next PC from the adder result or a control-flow target, and handshakes each fetch with instruction memory.
- Flags misaligned targets and fetch timeouts to the control FSM.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
ACK_TIMEOUT, 16, max cycles in FETCH waiting for IMEM_ACK before FETCH_ERR (range 1..255)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
PC_WRITE  in  1  control FSM request to advance PC (one-cycle pulse)
PC_SOURCE  in  3  next-PC select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6/7 treated as PC+4
PC_PLUS4  in  32  PC+4 from adder, combinational from PC
JALR  in  32  jalr target
BRANCH  in  32  branch target
JAL  in  32  jal target
MTVEC  in  32  trap vector
MEPC  in  32  exception return address
IMEM_ACK  in  1  instruction memory has captured/returned the word at IMEM_ADDR
PC  out  32  current PC register (feeds adder input and IMEM_ADDR)
IMEM_ADDR  out  32  equals PC combinationally
IMEM_REQ  out  1  fetch request
IR_VALID  out  1  instruction for PC is available; PC_WRITE accepted only while high
MISALIGN  out  1  sticky: rejected next-PC with [1:0] != 0
FETCH_ERR  out  1  sticky: ACK_TIMEOUT expired in FETCH
WAIT_CNT  out  8  cycles spent in current/last FETCH, saturates at 255

Behaviour:
- All state updates on rising CLK. RST is sampled synchronously and overrides everything in that cycle.
- Reset values: PC=RESET_VEC, state=START, IMEM_REQ=0, IR_VALID=0, MISALIGN=0, FETCH_ERR=0, WAIT_CNT=0.
- Outputs IMEM_REQ and IR_VALID are decoded from state only (Moore).
- States:
  - START: IMEM_REQ=0, IR_VALID=0. Next state FETCH unconditionally.
  - FETCH: IMEM_REQ=1, IR_VALID=0. WAIT_CNT increments each cycle without IMEM_ACK (saturating); it is cleared to 0 on entry to FETCH.
    - IMEM_ACK=1 → READY. A same-cycle ACK gives 1-cycle fetch latency.
    - WAIT_CNT reaches ACK_TIMEOUT-1 with no ACK → ERROR, FETCH_ERR<=1.
  - READY: IMEM_REQ=0, IR_VALID=1.
    - PC_WRITE=1: next = mux(PC_SOURCE).
      - next[1:0]==0 → PC<=next, MISALIGN<=0, go FETCH.
      - Otherwise → PC unchanged, MISALIGN<=1, stay READY.
  - ERROR: IMEM_REQ=0, IR_VALID=0. Held until RST.
- PC_WRITE outside READY is ignored; no PC change and no queuing.
- IMEM_ACK outside FETCH is ignored.
- Arithmetic: PC+4 is not computed here; the block trusts PC_PLUS4. Wrap-around is 32-bit: PC=32'hFFFF_FFFC with source 0 loads 32'h0000_0000 and is a legal aligned target.
- MISALIGN clears only on an accepted aligned PC_WRITE or RST. FETCH_ERR clears only on RST.
- RST mid-FETCH abandons the outstanding request: IMEM_REQ drops the next cycle and PC reloads RESET_VEC.
- Simultaneous IMEM_ACK and timeout in the same cycle: ACK wins → READY.

Test Plan:
- Reset, then ACK held high → PC=0, cycle 1 START, cycle 2 FETCH with IMEM_REQ=1, cycle 3 READY with IR_VALID=1, WAIT_CNT=0.
- In READY, PC_WRITE with source 0 and PC_PLUS4=4 → PC=4, FETCH; ACK after 3 cycles → WAIT_CNT=3, READY.
- Sources 1-5 with targets 0x100, 0x200, 0x300, 0x400, 0x500 → PC takes each value in turn; source 7 → PC=PC_PLUS4.
- JALR=0x102 selected → MISALIGN=1, PC unchanged, still READY; then JAL=0x300 selected → PC=0x300, MISALIGN=0.
- ACK never asserted, ACK_TIMEOUT=16 → FETCH_ERR=1 after 16 FETCH cycles, ERROR state, PC_WRITE ignored; RST → PC=RESET_VEC, FETCH_ERR=0.
- PC=0xFFFF_FFFC, source 0 with PC_PLUS4=0 → PC=0. Separately, RST asserted during FETCH → IMEM_REQ=0 next cycle and PC=RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer for the OTTER core.
// Holds PC, selects the next PC and handshakes each fetch with instruction memory.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] PC_PLUS4,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        IMEM_ACK,
  output logic [31:0] PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  output logic        IR_VALID,
  output logic        MISALIGN,
  output logic        FETCH_ERR,
  output logic [7:0]  WAIT_CNT,
  output logic [1:0]  DBG_STATE
);

  // Handshake: IMEM_REQ is high for every cycle spent in FETCH; the first
  // cycle with IMEM_ACK high completes the fetch and the word for PC is then
  // valid (IR_VALID) until the control FSM accepts a PC_WRITE.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] target;
  logic        misalign_q, misalign_nxt;
  logic        fetch_err_q, fetch_err_nxt;
  logic [7:0]  wait_q, wait_nxt;

  always_comb begin
    case (PC_SOURCE)
      3'd1:    target = JALR;
      3'd2:    target = BRANCH;
      3'd3:    target = JAL;
      3'd4:    target = MTVEC;
      3'd5:    target = MEPC;
      default: target = PC_PLUS4;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    misalign_nxt  = misalign_q;
    fetch_err_nxt = fetch_err_q;
    wait_nxt      = wait_q;
    case (state)
      ST_START: begin
        state_nxt = ST_FETCH;
        wait_nxt  = 8'd0;
      end
      ST_FETCH: begin
        // An ACK in the timeout cycle still completes the fetch.
        if (IMEM_ACK) begin
          state_nxt = ST_READY;
        end else begin
          if (wait_q != 8'hFF) wait_nxt = wait_q + 8'd1;
          if (wait_q == TIMEOUT_LAST) begin
            state_nxt     = ST_ERROR;
            fetch_err_nxt = 1'b1;
          end
        end
      end
      ST_READY: begin
        if (PC_WRITE) begin
          if (target[1:0] == 2'b00) begin
            pc_nxt       = target;
            misalign_nxt = 1'b0;
            wait_nxt     = 8'd0;
            state_nxt    = ST_FETCH;
          end else begin
            misalign_nxt = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt = ST_START;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_START;
      pc_q        <= RESET_VEC;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      wait_q      <= 8'd0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      misalign_q  <= misalign_nxt;
      fetch_err_q <= fetch_err_nxt;
      wait_q      <= wait_nxt;
    end
  end

  assign PC        = pc_q;
  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = (state == ST_FETCH);
  assign IR_VALID  = (state == ST_READY);
  assign MISALIGN  = misalign_q;
  assign FETCH_ERR = fetch_err_q;
  assign WAIT_CNT  = wait_q;
  assign DBG_STATE = state;

endmodule
